// File: rtl/link_pkg.sv
// Shared types and sizing helpers for the pulse-link transmit scheduler.
package link_pkg;

    // Payload width used when the Encoder width is not overridden.
    localparam int DEF_N_PKT = 8;

    // Scheduler states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        GAP       = 3'd4
    } link_state_t;

    // Width of a requester id (never narrower than one bit).
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold 0..max_val (never narrower than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/link_tx_scheduler_if.sv
// Requester and Encoder handshake bundle of the transmit scheduler.
// master = the scheduler, slave = requesters plus Encoder.
interface link_tx_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int N_PKT = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*N_PKT-1:0] req_data;
    logic [N_REQ-1:0]       ack;
    logic [N_REQ-1:0]       done;
    logic [N_PKT-1:0]       enc_data;
    logic                   enc_start;
    logic                   enc_avail;

    modport master (
        input  req, req_data, enc_avail,
        output ack, done, enc_data, enc_start
    );

    modport slave (
        output req, req_data, enc_avail,
        input  ack, done, enc_data, enc_start
    );
endinterface

// File: rtl/link_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter
    import link_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]           req,
    input  logic [id_width(N)-1:0] ptr,
    output logic                   valid,
    output logic [id_width(N)-1:0] winner
);
    localparam int ID_W = id_width(N);

    // Scan N positions starting at ptr; the first requesting one wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (int'(ptr) + i) % N;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = ID_W'(idx);
            end else begin
                valid  = valid;
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/link_tx_scheduler.sv
// Shares one pulse-link Encoder among N_REQ requesters: round-robin grant,
// payload latch, start/avail handshake, inter-packet gap and watchdog.
module link_tx_scheduler
    import link_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int N_PKT  = DEF_N_PKT,
    parameter int GAP_CT = 1000,
    parameter int MAX_TX = 200000
) (
    input  logic                       clk,
    input  logic                       rst,
    link_tx_scheduler_if.master        bus,
    output logic                       busy,
    output logic [id_width(N_REQ)-1:0] cur_id,
    output logic                       timeout_err,
    input  logic                       clr_err
);
    localparam int ID_W  = id_width(N_REQ);
    localparam int WD_W  = cnt_width(MAX_TX);
    localparam int GAP_W = cnt_width(GAP_CT);

    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'((MAX_TX > 0) ? MAX_TX - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CT > 0) ? GAP_CT - 1 : 0);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    link_state_t       state_r;
    link_state_t       next_state_s;
    logic [ID_W-1:0]   ptr_r;
    logic [ID_W-1:0]   cur_id_r;
    logic [N_PKT-1:0]  enc_data_r;
    logic [N_REQ-1:0]  ack_r;
    logic [N_REQ-1:0]  done_r;
    logic              enc_start_r;
    logic              busy_r;
    logic              timeout_err_r;
    logic [WD_W-1:0]   wd_r;
    logic [GAP_W-1:0]  gap_r;

    logic              arb_valid_s;
    logic [ID_W-1:0]   arb_winner_s;
    logic              grant_s;
    logic              finish_s;
    logic              timeout_s;
    logic              limit_s;
    logic              gap_end_s;
    link_state_t       post_tx_s;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req    (bus.req),
        .ptr    (ptr_r),
        .valid  (arb_valid_s),
        .winner (arb_winner_s)
    );

    assign bus.ack       = ack_r;
    assign bus.done      = done_r;
    assign bus.enc_data  = enc_data_r;
    assign bus.enc_start = enc_start_r;
    assign busy          = busy_r;
    assign cur_id        = cur_id_r;
    assign timeout_err   = timeout_err_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and the one-cycle event strobes that drive the datapath.
    always_comb begin
        next_state_s = state_r;
        grant_s      = 1'b0;
        finish_s     = 1'b0;
        timeout_s    = 1'b0;
        // wd_r counts cycles since the enc_start cycle, so a timeout's done
        // pulse lands exactly MAX_TX cycles after enc_start.
        limit_s      = (wd_r >= WD_LIMIT);
        gap_end_s    = (gap_r >= GAP_LAST);
        if (GAP_CT > 0) begin
            post_tx_s = GAP;
        end else begin
            post_tx_s = IDLE;
        end
        case (state_r)
            IDLE: begin
                if (bus.enc_avail && arb_valid_s) begin
                    grant_s      = 1'b1;
                    next_state_s = LAUNCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LAUNCH: begin
                next_state_s = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (limit_s) begin
                    timeout_s    = 1'b1;
                    next_state_s = post_tx_s;
                end else if (!bus.enc_avail) begin
                    next_state_s = WAIT_HIGH;
                end else begin
                    next_state_s = WAIT_LOW;
                end
            end
            WAIT_HIGH: begin
                // Completion wins over a watchdog limit hit in the same cycle.
                if (bus.enc_avail) begin
                    finish_s     = 1'b1;
                    next_state_s = post_tx_s;
                end else if (limit_s) begin
                    timeout_s    = 1'b1;
                    next_state_s = post_tx_s;
                end else begin
                    next_state_s = WAIT_HIGH;
                end
            end
            GAP: begin
                if (gap_end_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = GAP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Grant latches, RR pointer and the registered handshake pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r       <= '0;
            cur_id_r    <= '0;
            enc_data_r  <= '0;
            ack_r       <= '0;
            done_r      <= '0;
            enc_start_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            ack_r       <= '0;
            done_r      <= '0;
            enc_start_r <= 1'b0;
            busy_r      <= (next_state_s != IDLE);
            if (grant_s) begin
                cur_id_r    <= arb_winner_s;
                enc_data_r  <= bus.req_data[arb_winner_s * N_PKT +: N_PKT];
                ptr_r       <= (arb_winner_s == LAST_ID) ? '0 : arb_winner_s + ID_W'(1);
                ack_r       <= ONE_HOT0 << arb_winner_s;
                enc_start_r <= 1'b1;
            end
            if (finish_s || timeout_s) begin
                done_r <= ONE_HOT0 << cur_id_r;
            end
        end
    end

    // Watchdog and gap counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_r  <= '0;
            gap_r <= '0;
        end else begin
            if (grant_s) begin
                wd_r <= '0;
            end else if (state_r == LAUNCH || state_r == WAIT_LOW || state_r == WAIT_HIGH) begin
                wd_r <= wd_r + WD_W'(1);
            end
            if (state_r == GAP && !gap_end_s) begin
                gap_r <= gap_r + GAP_W'(1);
            end else begin
                gap_r <= '0;
            end
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err_r <= 1'b0;
        end else if (timeout_s) begin
            timeout_err_r <= 1'b1;
        end else if (clr_err) begin
            timeout_err_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Directed bench for link_tx_scheduler: table of grant sequences plus
// hand-written single-packet, timeout, reset and zero-gap sequences.
module tb_link_tx_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_a = 1'b0;
    logic clr_b = 1'b0;
    logic busy_a, busy_b, terr_a, terr_b;
    logic [1:0] cur_id_a, cur_id_b;

    int n_checks = 0;
    int n_errors = 0;

    link_tx_scheduler_if #(.N_REQ(4), .N_PKT(8)) ifa ();
    link_tx_scheduler_if #(.N_REQ(4), .N_PKT(8)) ifb ();

    link_tx_scheduler #(.N_REQ(4), .N_PKT(8), .GAP_CT(4), .MAX_TX(100)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa), .busy(busy_a), .cur_id(cur_id_a),
        .timeout_err(terr_a), .clr_err(clr_a)
    );

    link_tx_scheduler #(.N_REQ(4), .N_PKT(8), .GAP_CT(0), .MAX_TX(100)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb), .busy(busy_b), .cur_id(cur_id_b),
        .timeout_err(terr_b), .clr_err(clr_b)
    );

    always #5 clk = ~clk;

    // Encoder models: avail falls 3 cycles after the start cycle and rises 50
    // cycles later; in hang mode avail never falls.
    localparam int DROP = 3;
    localparam int LEN  = 50;
    logic [1:0] start_m;
    logic [1:0] avail_m;
    bit         act_m [2];
    int         cnt_m [2];
    bit         hang_m [2];

    assign start_m       = {ifb.enc_start, ifa.enc_start};
    assign ifa.enc_avail = avail_m[0];
    assign ifb.enc_avail = avail_m[1];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            avail_m <= 2'b11;
            for (int m = 0; m < 2; m++) begin
                act_m[m] <= 1'b0;
                cnt_m[m] <= 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (hang_m[m]) begin
                    act_m[m] <= 1'b0;
                end else if (act_m[m]) begin
                    if (cnt_m[m] == DROP - 1) avail_m[m] <= 1'b0;
                    if (cnt_m[m] == DROP + LEN - 1) begin
                        avail_m[m] <= 1'b1;
                        act_m[m]   <= 1'b0;
                    end
                    cnt_m[m] <= cnt_m[m] + 1;
                end else if (start_m[m]) begin
                    act_m[m] <= 1'b1;
                    cnt_m[m] <= 1;
                end
            end
        end
    end

    typedef struct packed {
        logic [3:0]      req;
        logic [31:0]     data;
        logic [2:0]      n;
        logic [3:0][1:0] ids;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((sel == 0 && ifa.ack != 4'b0) || (sel == 1 && ifb.ack != 4'b0)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((sel == 0 && ifa.done != 4'b0) || (sel == 1 && ifb.done != 4'b0)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy_a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        bit ok;
        int done_k, done_n, idle_k, terr_k, stray;
        logic [1:0] id;
        logic [3:0] exp_oh;

        vecs[0] = '{req: 4'b1111, data: 32'h44332211, n: 3'd4, ids: {2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[1] = '{req: 4'b0101, data: 32'h00C300C1, n: 3'd2, ids: {2'd0, 2'd0, 2'd2, 2'd0}};
        vecs[2] = '{req: 4'b1001, data: 32'hD40000D1, n: 3'd2, ids: {2'd0, 2'd0, 2'd0, 2'd3}};
        vecs[3] = '{req: 4'b0110, data: 32'h00E3E200, n: 3'd2, ids: {2'd0, 2'd0, 2'd2, 2'd1}};
        vecs[4] = '{req: 4'b0011, data: 32'h0000F2F1, n: 3'd2, ids: {2'd0, 2'd0, 2'd1, 2'd0}};

        hang_m[0] = 1'b0;
        hang_m[1] = 1'b0;
        ifa.req = 4'b0; ifa.req_data = 32'h0;
        ifb.req = 4'b0; ifb.req_data = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", ifa.ack, 4'b0);
        check("rst_done", ifa.done, 4'b0);
        check("rst_start", ifa.enc_start, 1'b0);
        check("rst_data", ifa.enc_data, 8'h00);
        check("rst_busy", busy_a, 1'b0);
        check("rst_cur_id", cur_id_a, 2'd0);
        check("rst_terr", terr_a, 1'b0);
        rst = 1'b0;

        // Single request: ack/start next cycle, one done, busy low after gap
        @(negedge clk);
        ifa.req = 4'b0010; ifa.req_data = 32'h0000A500;
        @(negedge clk);
        check("one_ack", ifa.ack, 4'b0010);
        check("one_start", ifa.enc_start, 1'b1);
        check("one_data", ifa.enc_data, 8'hA5);
        check("one_cur_id", cur_id_a, 2'd1);
        check("one_busy", busy_a, 1'b1);
        ifa.req = 4'b0;
        done_k = -1; done_n = 0; idle_k = -1;
        for (int k = 2; k <= 70; k++) begin
            @(negedge clk);
            if (k == 10) check("one_data_hold", ifa.enc_data, 8'hA5);
            if (ifa.done != 4'b0) begin
                done_n++;
                if (done_k < 0) done_k = k;
                check("one_done_val", ifa.done, 4'b0010);
            end
            if (idle_k < 0 && !busy_a) idle_k = k;
        end
        check("one_done_cycle", done_k, 55);
        check("one_done_count", done_n, 1);
        check("one_idle_cycle", idle_k, 59);

        // Fresh pointer for the round-robin table
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            ifa.req      = vecs[v].req;
            ifa.req_data = vecs[v].data;
            for (int g = 0; g < int'(vecs[v].n); g++) begin
                id = vecs[v].ids[g];
                exp_oh = 4'b0001 << id;
                wait_ack(0, ok);
                check("tbl_ack_seen", ok, 1'b1);
                check("tbl_ack", ifa.ack, exp_oh);
                check("tbl_start", ifa.enc_start, 1'b1);
                check("tbl_data", ifa.enc_data, vecs[v].data[id*8 +: 8]);
                check("tbl_cur_id", cur_id_a, id);
                ifa.req[id] = 1'b0;
                wait_done(0, ok);
                check("tbl_done", ifa.done, exp_oh);
            end
            wait_idle(ok);
            check("tbl_idle", ok, 1'b1);
        end

        // Watchdog: Encoder never drops avail
        hang_m[0] = 1'b1;
        @(negedge clk);
        ifa.req = 4'b0100; ifa.req_data = 32'h00770000;
        @(negedge clk);
        check("to_ack", ifa.ack, 4'b0100);
        ifa.req = 4'b0;
        done_k = -1; terr_k = -1;
        for (int k = 2; k <= 110; k++) begin
            @(negedge clk);
            if (done_k < 0 && ifa.done != 4'b0) begin
                done_k = k;
                check("to_done_val", ifa.done, 4'b0100);
            end
            if (terr_k < 0 && terr_a) terr_k = k;
        end
        check("to_done_cycle", done_k, 101);
        check("to_err_cycle", terr_k, 101);
        wait_idle(ok);
        hang_m[0] = 1'b0;
        ifa.req = 4'b1000; ifa.req_data = 32'h88000000;
        wait_ack(0, ok);
        check("to_next_ack", ifa.ack, 4'b1000);
        check("to_next_data", ifa.enc_data, 8'h88);
        ifa.req = 4'b0;
        wait_done(0, ok);
        check("to_next_done", ifa.done, 4'b1000);
        check("to_err_sticky", terr_a, 1'b1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("to_err_cleared", terr_a, 1'b0);
        wait_idle(ok);

        // Reset in WAIT_HIGH: immediate clear, no done, pointer back to 0
        @(negedge clk);
        ifa.req = 4'b0010; ifa.req_data = 32'h00005500;
        wait_ack(0, ok);
        check("rm_ack", ifa.ack, 4'b0010);
        ifa.req = 4'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rm_busy", busy_a, 1'b0);
        check("rm_cur_id", cur_id_a, 2'd0);
        check("rm_data", ifa.enc_data, 8'h00);
        check("rm_done", ifa.done, 4'b0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (70) begin
            @(negedge clk);
            if (ifa.done != 4'b0) stray++;
        end
        check("rm_no_done", stray, 0);
        ifa.req = 4'b1111; ifa.req_data = 32'h44332211;
        wait_ack(0, ok);
        check("rm_ptr0_ack", ifa.ack, 4'b0001);
        ifa.req = 4'b0;
        wait_done(0, ok);
        check("rm_done_after", ifa.done, 4'b0001);

        // Zero gap: back-to-back grant one cycle after done; withdrawn req ignored
        @(negedge clk);
        ifb.req = 4'b0011; ifb.req_data = 32'h0000B2B1;
        wait_ack(1, ok);
        check("b_ack0", ifb.ack, 4'b0001);
        ifb.req[0] = 1'b0;
        wait_done(1, ok);
        check("b_done0", ifb.done, 4'b0001);
        @(negedge clk);
        check("b_ack1_next", ifb.ack, 4'b0010);
        check("b_start1", ifb.enc_start, 1'b1);
        check("b_data1", ifb.enc_data, 8'hB2);
        ifb.req[1] = 1'b0;
        repeat (10) @(negedge clk);
        ifb.req[2] = 1'b1; ifb.req_data = 32'h00B30000;
        repeat (5) @(negedge clk);
        ifb.req[2] = 1'b0;
        wait_done(1, ok);
        check("b_done1", ifb.done, 4'b0010);
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifb.ack != 4'b0 || ifb.enc_start) stray++;
        end
        check("b_no_stray", stray, 0);
        check("b_idle", busy_b, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/link_tx_scheduler.md
Name: link_tx_scheduler

Overview:
Shares the single pulse-link Encoder among N_REQ local requesters. Arbitrates round-robin, latches the winner's packet, and drives the Encoder's data/start handshake. Tracks completion via the Encoder's avail signal, enforces an inter-packet gap, and flags a watchdog timeout. Sits between the board/user logic and the Encoder; the Decoder side is untouched.

Parameters:
N_REQ, 4, number of requesters (>=2)
N_PKT, 8, packet payload width in bits (must match Encoder N_PKT)
GAP_CT, 1000, idle clk cycles between end of one packet and next grant (0 = no gap)
MAX_TX, 200000, watchdog limit in clk cycles from enc_start to packet completion

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst  in  1  asynchronous reset, active-high
req  in  N_REQ  per-requester send request, level, held until ack
req_data  in  N_REQ*N_PKT  flattened payloads; slice i = req_data[i*N_PKT +: N_PKT]
ack  out  N_REQ  one-hot, 1-cycle pulse: payload i captured, req i may drop
done  out  N_REQ  one-hot, 1-cycle pulse: packet i fully transmitted (or aborted by timeout)
enc_data  out  N_PKT  payload to Encoder.data
enc_start  out  1  1-cycle start pulse to Encoder.start
enc_avail  in  1  Encoder.avail: 1 = idle/ready, 0 = transmitting
busy  out  1  1 in every state except IDLE
cur_id  out  $clog2(N_REQ)  id of requester currently owning the link
timeout_err  out  1  sticky watchdog flag
clr_err  in  1  synchronous clear of timeout_err

Behaviour:
- Reset (async, rst=1): state IDLE; ack=0, done=0, enc_start=0, enc_data=0, busy=0, cur_id=0, timeout_err=0, RR pointer=0, counters=0. Reset mid-packet abandons it silently (no done).
- States: IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, GAP.
- IDLE: if enc_avail=1 and |req: winner = first set req bit scanning from pointer upward with wrap; register cur_id=winner, enc_data=req_data slice; pointer <= winner+1 mod N_REQ; go LAUNCH. Otherwise stay. Pointer changes only on grant.
- LAUNCH (1 cycle): enc_start=1, ack[cur_id]=1; watchdog cleared to 0. Go WAIT_LOW. Grant latency: req sampled at edge k -> ack/enc_start high in cycle k+1.
- WAIT_LOW: wait for enc_avail=0 -> WAIT_HIGH.
- WAIT_HIGH: wait for enc_avail=1 -> done[cur_id]=1 for that one cycle (Moore on transition, registered), go GAP (or IDLE if GAP_CT=0).
- Watchdog: counts every cycle in WAIT_LOW/WAIT_HIGH; on reaching MAX_TX: timeout_err<=1, done[cur_id] pulsed, go GAP/IDLE. Completion in the same cycle as limit counts as success.
- GAP: counter 0..GAP_CT-1, then IDLE; requests held off meanwhile.
- enc_data and cur_id stable from LAUNCH until the next grant.
- req deasserted before grant: ignored, no ack. req held after ack: treated as a new request at next arbitration.
- clr_err=1 clears timeout_err; if a timeout fires in the same cycle, set wins.
- Counter widths: $clog2(MAX_TX+1), $clog2(GAP_CT+1) (min 1).

Decomposition:
- link_pkg: state enum (IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, GAP), ID_W function/localparam, default N_PKT.
- Sub-module rr_arbiter #(N): inputs req, ptr, output valid + winner index, purely combinational. The FSM, latches and counters live in link_tx_scheduler.

Test Plan:
- Single request: req=4'b0010, data1=8'hA5, Encoder model drops avail 3 cycles after start and raises it 50 cycles later -> ack=4'b0010 and enc_start in the cycle after req, enc_data=8'hA5, done=4'b0010 exactly once, busy low GAP_CT cycles after done.
- Round-robin: req=4'b1111 held, each ack dropping its bit -> grant order 0,1,2,3; then req=4'b0101 with pointer=0 -> order 0,2.
- Wrap: pointer=3, req=4'b1001 -> grant 3, then 0.
- Timeout: Encoder model never lowers avail, MAX_TX=100 -> timeout_err=1 and done pulse at 100 cycles after start, next request still served; clr_err clears it.
- Reset mid-packet in WAIT_HIGH -> all outputs 0 immediately (async), no done, next req granted from pointer 0.
- GAP_CT=0 with back-to-back req -> next ack 1 cycle after done; withdraw req before grant -> no ack, no enc_start.
